// File: rtl/mac_sequencer.sv
// Control sequencer for the 16x16 MAC core: clear, weight load, data stream,
// then a per-row COMP / wait / present loop that drains every result row.
module mac_sequencer #(
  parameter int unsigned LANES   = 16,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned RW      = 4,
  parameter int unsigned MAC_LAT = 3,
  parameter int unsigned OUT_LAT = 2
) (
  input  logic             Clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             abort,
  input  logic [AW-1:0]    numTaps,
  input  logic [LANES-1:0] laneMask,
  input  logic             wValid,
  output logic             wReady,
  input  logic             dValid,
  output logic             dReady,
  output logic             resValid,
  input  logic             resReady,
  output logic [RW-1:0]    resRow,
  output logic             macWE,
  output logic             macNewData,
  output logic             macComp,
  output logic [RW-1:0]    macRow,
  output logic [AW-1:0]    macAddr,
  output logic [LANES-1:0] macAddrEn,
  output logic [LANES-1:0] macReset,
  output logic             busy,
  output logic             done
);

  // Tap count needs one extra bit so that DEPTH itself is representable.
  localparam int unsigned TW     = AW + 1;
  localparam int unsigned LatMax = (MAC_LAT > OUT_LAT) ? MAC_LAT : OUT_LAT;
  localparam int unsigned LW     = (LatMax > 1) ? $clog2(LatMax + 1) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StLoad,
    StCompute,
    StSettle,
    StDrain,
    StWait,
    StPresent,
    StDone
  } stateT;

  stateT            stateQ, stateD;
  logic [TW-1:0]    tapsQ, tapsD;
  logic [LANES-1:0] maskQ, maskD;
  logic [AW-1:0]    wCntQ, wCntD;
  logic [AW-1:0]    dCntQ, dCntD;
  logic [LW-1:0]    latQ, latD;
  logic [RW-1:0]    rowQ, rowD;
  logic             abortedQ, abortedD;

  logic [TW-1:0]    lastIdx;
  logic             wLast, dLast, wHs, dHs;

  // State and counter registers; reset is asynchronous and abandons any tile in flight.
  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) begin
      stateQ   <= StIdle;
      tapsQ    <= '0;
      maskQ    <= '0;
      wCntQ    <= '0;
      dCntQ    <= '0;
      latQ     <= '0;
      rowQ     <= '0;
      abortedQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      tapsQ    <= tapsD;
      maskQ    <= maskD;
      wCntQ    <= wCntD;
      dCntQ    <= dCntD;
      latQ     <= latD;
      rowQ     <= rowD;
      abortedQ <= abortedD;
    end
  end

  // Next-state and core control decode; abort overrides everything outside idle.
  always_comb begin
    stateD     = stateQ;
    tapsD      = tapsQ;
    maskD      = maskQ;
    wCntD      = wCntQ;
    dCntD      = dCntQ;
    latD       = latQ;
    rowD       = rowQ;
    abortedD   = abortedQ;
    wReady     = 1'b0;
    dReady     = 1'b0;
    resValid   = 1'b0;
    resRow     = '0;
    macWE      = 1'b0;
    macNewData = 1'b0;
    macComp    = 1'b0;
    macRow     = '0;
    macAddr    = '0;
    macAddrEn  = '0;
    macReset   = '0;
    done       = 1'b0;
    busy       = (stateQ != StIdle);

    lastIdx = tapsQ - 1'b1;
    wLast   = ({1'b0, wCntQ} == lastIdx);
    dLast   = ({1'b0, dCntQ} == lastIdx);
    // Ready is withdrawn under abort so a coincident handshake never takes place.
    wHs     = (stateQ == StLoad) && !abort && wValid;
    dHs     = (stateQ == StCompute) && !abort && dValid;

    unique case (stateQ)
      StIdle: begin
        if (start && !abort) begin
          tapsD  = (numTaps == '0) ? TW'(DEPTH) : {1'b0, numTaps};
          maskD  = laneMask;
          stateD = StClear;
        end
      end
      StClear: begin
        macReset = '1;
        wCntD    = '0;
        dCntD    = '0;
        latD     = '0;
        rowD     = '0;
        abortedD = 1'b0;
        stateD   = abortedQ ? StIdle : StLoad;
      end
      StLoad: begin
        wReady  = !abort;
        macWE   = wHs;
        macAddr = wCntQ;
        if (wHs) begin
          if (wLast) begin
            wCntD  = '0;
            stateD = StCompute;
          end else begin
            wCntD = wCntQ + 1'b1;
          end
        end
      end
      StCompute: begin
        dReady     = !abort;
        macNewData = dHs;
        macAddr    = dCntQ;
        macAddrEn  = maskQ;
        if (dHs) begin
          if (dLast) begin
            latD   = '0;
            stateD = StSettle;
          end else begin
            dCntD = dCntQ + 1'b1;
          end
        end
      end
      StSettle: begin
        if (latQ == LW'(MAC_LAT - 1)) begin
          latD   = '0;
          rowD   = '0;
          stateD = StDrain;
        end else begin
          latD = latQ + 1'b1;
        end
      end
      StDrain: begin
        macComp = 1'b1;
        macRow  = rowQ;
        latD    = '0;
        stateD  = StWait;
      end
      StWait: begin
        macRow = rowQ;
        if (latQ == LW'(OUT_LAT - 1)) begin
          latD   = '0;
          stateD = StPresent;
        end else begin
          latD = latQ + 1'b1;
        end
      end
      StPresent: begin
        resValid = 1'b1;
        resRow   = rowQ;
        macRow   = rowQ;
        if (resReady && !abort) begin
          if (rowQ == RW'(LANES - 1)) begin
            stateD = StDone;
          end else begin
            rowD   = rowQ + 1'b1;
            stateD = StDrain;
          end
        end
      end
      StDone: begin
        done   = !abort;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase

    if (abort && (stateQ != StIdle)) begin
      stateD   = StClear;
      abortedD = 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: expected addresses and rows are queued per tile
// and popped by a negedge monitor as the DUT emits WE / NEWDATA / COMP / result handshakes.
module tb_mac_sequencer;

  localparam int LANES = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int RW    = 4;

  logic             Clk = 1'b0;
  logic             resetN = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [AW-1:0]    numTaps = '0;
  logic [LANES-1:0] laneMask = '0;
  logic             wValid = 1'b0;
  logic             dValid = 1'b0;
  logic             resReady = 1'b0;
  logic             wReady, dReady, resValid;
  logic [RW-1:0]    resRow, macRow;
  logic             macWE, macNewData, macComp, busy, done;
  logic [AW-1:0]    macAddr;
  logic [LANES-1:0] macAddrEn, macReset;

  int total, bad;
  int wQ[$], dQ[$], cQ[$], rQ[$];

  // Monitor bookkeeping.
  bit               monEn = 1'b0;
  int               mcyc, doneCnt, resetCyc, computeCyc, weCnt, ndCnt, stallCyc;
  int               lastNdCyc, compCyc, lastCompRow, lastWeAddr;
  bit               compPending, prevResValid, prevResReady, prevWStall;
  logic [RW-1:0]    prevResRow;
  logic [AW-1:0]    prevAddr;
  logic [LANES-1:0] expMask;

  mac_sequencer dut (
    .Clk        (Clk),
    .resetN     (resetN),
    .start      (start),
    .abort      (abort),
    .numTaps    (numTaps),
    .laneMask   (laneMask),
    .wValid     (wValid),
    .wReady     (wReady),
    .dValid     (dValid),
    .dReady     (dReady),
    .resValid   (resValid),
    .resReady   (resReady),
    .resRow     (resRow),
    .macWE      (macWE),
    .macNewData (macNewData),
    .macComp    (macComp),
    .macRow     (macRow),
    .macAddr    (macAddr),
    .macAddrEn  (macAddrEn),
    .macReset   (macReset),
    .busy       (busy),
    .done       (done)
  );

  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkEq({tag, "Ctl"}, {wReady, dReady, resValid, resRow, macWE, macNewData, macComp,
                           macRow, macAddr, busy, done}, 0);
    checkEq({tag, "AddrEn"}, macAddrEn, 0);
    checkEq({tag, "MacReset"}, macReset, 0);
  endtask

  task automatic flushAll();
    wQ.delete();
    dQ.delete();
    cQ.delete();
    rQ.delete();
    compPending = 1'b0;
  endtask

  // Negedge monitor: pops the scoreboard and checks timing/stability rules.
  always @(negedge Clk) begin
    int hot;
    int want;
    if (resetN && monEn) begin
      mcyc++;
      hot = int'(macWE) + int'(macNewData) + int'(macComp) + int'(|macReset);
      if (hot != 0) checkEq("oneHot", hot, 1);
      if (macReset != '0) begin
        checkEq("resetVal", macReset, 16'hFFFF);
        resetCyc++;
      end
      if (wReady) begin
        checkEq("weFollow", macWE, wValid);
        if (prevWStall) checkEq("wAddrHold", macAddr, prevAddr);
        prevWStall = !wValid;
        prevAddr   = macAddr;
      end else begin
        prevWStall = 1'b0;
      end
      if (macWE) begin
        if (wQ.size() == 0) checkEq("extraWE", macWE, 0);
        else checkEq("weAddr", macAddr, wQ.pop_front());
        weCnt++;
        lastWeAddr = int'(macAddr);
      end
      if (dReady) computeCyc++;
      if (macNewData) begin
        checkEq("addrEn", macAddrEn, expMask);
        if (dQ.size() == 0) checkEq("extraND", macNewData, 0);
        else checkEq("ndAddr", macAddr, dQ.pop_front());
        ndCnt++;
        lastNdCyc = mcyc;
      end else if (!dReady && !abort && macAddrEn != '0) begin
        checkEq("addrEnIdle", macAddrEn, 0);
      end
      if (macComp) begin
        if (cQ.size() == 0) begin
          checkEq("extraComp", macComp, 0);
        end else begin
          want = cQ.pop_front();
          checkEq("compRow", macRow, want);
          if (want == 0) checkEq("settleGap", mcyc - lastNdCyc, 4);
        end
        checkEq("compWhilePending", compPending, 0);
        compPending = 1'b1;
        compCyc     = mcyc;
        lastCompRow = int'(macRow);
      end else if (busy && compPending && !resValid) begin
        checkEq("waitRow", macRow, lastCompRow);
      end
      if (resValid && !prevResValid) checkEq("outLat", mcyc - compCyc, 3);
      if (prevResValid && !prevResReady) begin
        checkEq("resHold", resValid, 1);
        checkEq("resRowHold", resRow, prevResRow);
      end
      if (resValid && !resReady) stallCyc++;
      if (resValid && resReady) begin
        if (rQ.size() == 0) checkEq("extraRes", resValid, 0);
        else checkEq("resRow", resRow, rQ.pop_front());
        compPending = 1'b0;
      end
      if (done) doneCnt++;
      prevResValid = resValid;
      prevResReady = resReady;
      prevResRow   = resRow;
    end else begin
      prevResValid = 1'b0;
      prevResReady = 1'b0;
      prevWStall   = 1'b0;
    end
  end

  // One tile with optional weight toggling, data gap, result stall, abort, reset or mid-tile start.
  task automatic runTile(input int taps, input logic [15:0] mask, input bit wTog, input int gapAt,
                         input int stallRow, input int stallLen, input int abortAt,
                         input int rstRow, input bit midStart);
    int n, wHs, dHs, gapLeft, stallLeft, cyc, doneBefore;
    bit fin, wasW, wasD, midDone;
    n = (taps == 0) ? DEPTH : taps;
    wHs = 0; dHs = 0; gapLeft = 3; stallLeft = stallLen; cyc = 0;
    fin = 1'b0; midDone = 1'b0;
    doneBefore = doneCnt;
    resetCyc = 0; computeCyc = 0; weCnt = 0; ndCnt = 0; stallCyc = 0;
    compPending = 1'b0; lastCompRow = -1; lastWeAddr = -1;
    expMask = mask;
    for (int i = 0; i < n; i++) begin
      wQ.push_back(i);
      dQ.push_back(i);
    end
    for (int r = 0; r < LANES; r++) begin
      cQ.push_back(r);
      rQ.push_back(r);
    end
    @(posedge Clk); #1;
    numTaps = AW'(taps); laneMask = mask; start = 1'b1;
    wValid = 1'b1; dValid = 1'b1; resReady = 1'b1;
    while (!fin && cyc < 2000) begin
      @(negedge Clk);
      wasW = wValid && wReady;
      wasD = dValid && dReady;
      @(posedge Clk); #1;
      cyc++;
      start = 1'b0;
      if (wasW) wHs++;
      if (wasD) dHs++;
      wValid = wTog ? !wValid : 1'b1;
      if (gapAt >= 0 && dReady && dHs == gapAt && gapLeft > 0) begin
        dValid = 1'b0;
        gapLeft--;
      end else begin
        dValid = 1'b1;
      end
      if (resValid && int'(resRow) == stallRow && stallLeft > 0) begin
        resReady = 1'b0;
        stallLeft--;
      end else begin
        resReady = 1'b1;
      end
      if (midStart && !midDone && wReady && wHs == 1) begin
        start = 1'b1;
        numTaps = 5'd7;
        midDone = 1'b1;
      end
      if (doneCnt != doneBefore) begin
        fin = 1'b1;
      end else if (abortAt >= 0 && dReady && dHs == abortAt) begin
        abort = 1'b1;
        #1;
        checkEq("abortNoReady", dReady, 0);
        @(posedge Clk); #1;
        abort = 1'b0;
        checkEq("abortClear", macReset, 16'hFFFF);
        checkEq("abortBusy", busy, 1);
        @(posedge Clk); #1;
        checkEq("abortIdle", busy, 0);
        repeat (3) @(posedge Clk);
        #1;
        checkEq("abortNoDone", doneCnt - doneBefore, 0);
        checkEq("abortClears", resetCyc, 2);
        checkEq("abortTaps", ndCnt, abortAt);
        fin = 1'b1;
      end else if (rstRow >= 0 && lastCompRow == rstRow) begin
        #2;
        checkEq("rstBusyBefore", busy, 1);
        resetN = 1'b0;
        #1;
        checkQuiet("rstMid");
        flushAll();
        @(posedge Clk);
        @(posedge Clk);
        #2;
        checkQuiet("rstHeld");
        resetN = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checkEq("rstNoDone", doneCnt - doneBefore, 0);
        checkEq("rstIdle", busy, 0);
        fin = 1'b1;
      end
    end
    if (!fin) begin
      checkEq("timeout", cyc, 0);
    end else if (abortAt < 0 && rstRow < 0) begin
      repeat (3) @(posedge Clk);
      #1;
      checkEq("doneOnce", doneCnt - doneBefore, 1);
      checkEq("idleAfter", busy, 0);
      checkEq("clearOnce", resetCyc, 1);
      checkEq("weCount", weCnt, n);
      checkEq("ndCount", ndCnt, n);
      checkEq("computeCyc", computeCyc, n + ((gapAt >= 0) ? 3 : 0));
      checkEq("stallCyc", stallCyc, stallLen);
      checkEq("lastWeAddr", lastWeAddr, n - 1);
      checkEq("leftover", wQ.size() + dQ.size() + cQ.size() + rQ.size(), 0);
    end
    flushAll();
  endtask

  initial begin
    total = 0; bad = 0; mcyc = 0; doneCnt = 0;
    #3;
    checkQuiet("rst0");
    #20;
    resetN = 1'b1;
    monEn  = 1'b1;
    #1;
    checkQuiet("idle0");

    // start together with abort in idle: abort wins.
    @(posedge Clk); #1;
    start = 1'b1; abort = 1'b1; numTaps = 5'd4;
    @(posedge Clk); #1;
    start = 1'b0; abort = 1'b0;
    checkEq("startAbortIdle", busy, 0);
    checkEq("startAbortNoClear", macReset, 0);

    //      taps mask      tog gap stR stL abt rst mid
    runTile(4,   16'hFFFF, 0,  -1, -1, 0,  -1, -1, 0);
    runTile(0,   16'hA5A5, 0,  -1, -1, 0,  -1, -1, 0);
    runTile(4,   16'h00FF, 1,  2,  -1, 0,  -1, -1, 1);
    runTile(2,   16'hFFFF, 0,  -1, 5,  10, -1, -1, 0);
    runTile(8,   16'hFFFF, 0,  -1, -1, 0,  2,  -1, 0);
    runTile(5,   16'hFFFF, 0,  -1, -1, 0,  -1, 3,  0);
    runTile(3,   16'h1234, 0,  -1, -1, 0,  -1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
